issue_buffer: RTL
=================

# issue_buffer

Generic in-order-compacted reservation buffer that holds dispatched micro-ops for one execution class (shift, ALU, branch) until the issue stage selects them. It sits between dispatch and the issue-select logic. It accepts one entry per cycle at the tail and releases one entry per cycle from any slot. The remaining entries are kept packed oldest-first, so a leading-one select at the issue stage always picks the oldest ready op.

## Interface
Parameters:
- DW, 200: width of one entry (decoded op flags, pc, imm, renamed rd/rs1/rs2 indices)
- DP, 4: number of slots; power of two, at least 2

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  asynchronous, active-high reset
- push  in  1  write push_data into the buffer this cycle
- push_data  in  DW  entry to store
- pop  in  1  remove slot pop_index this cycle
- pop_index  in  $clog2(DP)  slot to remove; 0 is the oldest entry
- flush  in  1  discard all entries (mispredict/exception)
- full  out  1  count == DP
- empty  out  1  count == 0
- count  out  $clog2(DP)+1  number of valid entries
- valid_qout  out  DP  per-slot valid; always thermometer-coded (slots 0..count-1 set)
- info_qout  out  DW*DP  flattened slot contents; slot i occupies [DW*i +: DW]

## Operation
- State: DP×DW data registers and a count register. valid_qout[i] = (i < count).
- Push only (no effective pop): write slot[count], then count+1.
- Pop only: slot[j] ← slot[j+1] for all j ≥ pop_index and j < DP-1, then count-1. The vacated top slot keeps stale data; its valid bit is 0.
- Push and pop in the same cycle: shift down as for pop, write push_data to slot[count-1], count unchanged.
- Effective pop = pop & valid_qout[pop_index]. A pop to an invalid slot is ignored.
- Effective push = push & (~full | effective pop). A push to a full buffer with no pop is dropped. The upstream ready logic prevents this, and the bench asserts it never occurs.
- Push while empty with pop asserted: pop is ignored because the slot is invalid, and the push lands in slot 0.
- Flush has priority over push and pop: count ← 0 next cycle and the data registers are left unchanged. A push in the flush cycle is discarded.
- Age order is preserved at all times: slot i is older than slot i+1.

## Timing
- Reset (async assert, sync-safe release): count=0, empty=1, full=0, valid_qout=0, info_qout=0.
- All outputs are registered (or decode only registered count). There is no combinational path from push/pop/flush to any output.
- Push latency is 1 cycle: the entry is visible on info_qout/valid_qout on the edge after push.
- Pop takes effect on the next edge. pop_index is driven combinationally by the issue select from this cycle's qout, which is legal because the outputs are registered.
- Throughput is one push plus one pop per cycle, sustained, including at full.
- If RST asserts mid-operation, all entries are lost immediately. Nothing is retained across reset.

## Structure
- DP defaults per class (for example SHIFT_ISSUE_DEPTH=4) and the RNBIT-dependent entry-width constants live in the shared core define package. DW is computed there per class.
- The block is a single module with no sub-module. The shift-down network is a generate loop using a per-slot mux: hold, take slot[j+1], or take push_data.
- An optional assertion checks that push & full & ~pop is never true.

## Test plan
- Reset, then push A, B, C, D on four consecutive cycles: full=1, count=4, slots 0..3 = A, B, C, D, valid_qout=4'b1111.
- From full {A,B,C,D}, pop index 1 with no push: next cycle count=3, slots 0..2 = A, C, D, valid_qout=4'b0111, full=0.
- From full {A,B,C,D}, push E together with pop index 0: count stays 4, slots = B, C, D, E, full stays 1.
- Empty buffer, push F with pop index 2: count=1, slot0=F, and the pop is ignored.
- Buffer {A,B,C}, flush together with push G: next cycle count=0, empty=1, valid_qout=0. A subsequent push H lands in slot 0.
- Random push/pop/flush for 10k cycles against a queue reference model: contents, order and count match every cycle, and the thermometer invariant on valid_qout holds.

Source files
------------

// File: rtl/issue_buffer_pkg.sv
// Shared core constants for issue buffers: per-class depths, rename width and entry-width helper.
// Also holds the per-slot update selector used by the compaction network.
package issue_buffer_pkg;

    localparam int RNBIT             = 6;
    localparam int PC_W              = 32;
    localparam int IMM_W             = 32;
    localparam int SHIFT_OP_FLAGS    = 118;
    localparam int SHIFT_ISSUE_DEPTH = 4;

    typedef enum logic [1:0] {
        SEL_HOLD  = 2'd0,
        SEL_SHIFT = 2'd1,
        SEL_PUSH  = 2'd2
    } slot_sel_e;

    // Entry = op flags + pc + imm + renamed rd/rs1/rs2.
    function automatic int issue_entry_width(input int op_flags);
        return op_flags + PC_W + IMM_W + 3 * RNBIT;
    endfunction

endpackage

// File: rtl/issue_buffer.sv
// Oldest-first compacted reservation buffer: one push at the tail and one pop from any
// slot per cycle; survivors shift down so slot 0 is always the oldest entry.
module issue_buffer
    import issue_buffer_pkg::*;
#(
    parameter int DW = issue_entry_width(SHIFT_OP_FLAGS),
    parameter int DP = SHIFT_ISSUE_DEPTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  push,
    input  logic [DW-1:0]         push_data,
    input  logic                  pop,
    input  logic [$clog2(DP)-1:0] pop_index,
    input  logic                  flush,
    output logic                  full,
    output logic                  empty,
    output logic [$clog2(DP):0]   count,
    output logic [DP-1:0]         valid_qout,
    output logic [DW*DP-1:0]      info_qout
);

    localparam int PW = $clog2(DP);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DP);

    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;
    logic [CW-1:0] w_wr_idx;
    logic [DP-1:0] w_valid;
    logic          w_full;
    logic          w_pop_eff;
    logic          w_push_eff;

    assign w_full     = (r_count == FULL_CNT);
    assign w_pop_eff  = pop & w_valid[pop_index];
    // A simultaneous pop frees a slot, so a push is accepted even when full.
    assign w_push_eff = push & (~w_full | w_pop_eff);
    assign w_wr_idx   = w_pop_eff ? (r_count - CW'(1)) : r_count;

    always_comb begin
        w_count_next = r_count;
        if (flush) begin
            w_count_next = '0;
        end else if (w_push_eff && !w_pop_eff) begin
            w_count_next = r_count + CW'(1);
        end else if (!w_push_eff && w_pop_eff) begin
            w_count_next = r_count - CW'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    for (genvar gi = 0; gi < DP; gi++) begin : g_slot
        logic [DW-1:0] r_slot;
        logic [DW-1:0] w_above;
        slot_sel_e     w_sel;

        assign w_valid[gi] = (CW'(gi) < r_count);

        // The top slot has nothing above it; a pop leaves it stale but invalid.
        if (gi < DP - 1) begin : g_shift
            assign w_above = info_qout[DW*(gi+1) +: DW];
        end else begin : g_top
            assign w_above = r_slot;
        end

        always_comb begin
            w_sel = SEL_HOLD;
            if (!flush) begin
                if (w_push_eff && (w_wr_idx == CW'(gi))) begin
                    w_sel = SEL_PUSH;
                end else if (w_pop_eff && (PW'(gi) >= pop_index)) begin
                    w_sel = SEL_SHIFT;
                end
            end
        end

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                r_slot <= '0;
            end else begin
                case (w_sel)
                    SEL_PUSH:  r_slot <= push_data;
                    SEL_SHIFT: r_slot <= w_above;
                    default:   r_slot <= r_slot;
                endcase
            end
        end

        assign info_qout[DW*gi +: DW] = r_slot;
    end

    assign full       = w_full;
    assign empty      = (r_count == '0);
    assign count      = r_count;
    assign valid_qout = w_valid;

endmodule
